// File: rtl/program_loader_if.sv
// Pin-side byte handshake, program-memory write port and status outputs of the program loader.
// The checksum signal exists only when LOADER_CHECKSUM_EN is defined.
interface program_loader_if #(
    parameter int ADDR_W = 5
);
    logic              load_mode;
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic              byte_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic [ADDR_W:0]   word_count;
    logic              load_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    modport master (
        output load_mode, byte_valid, byte_in,
        input  byte_ack, mem_we, mem_addr, mem_wdata, cpu_run, word_count, load_err
`ifdef LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  load_mode, byte_valid, byte_in,
        output byte_ack, mem_we, mem_addr, mem_wdata, cpu_run, word_count, load_err
`ifdef LOADER_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/program_loader.sv
// Host-side program loader: assembles handshaken pin bytes into 32-bit words and writes them to
// program memory while the CPU is held. Optional running XOR checksum via LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    program_loader_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] RUN    = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [SYNC_STAGES-1:0] lm_sync_q;
    logic [SYNC_STAGES-1:0] valid_sync_q;
    logic                   valid_prev;
    logic                   lm;
    logic                   valid_s;
    logic                   valid_rise;

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [1:0]  idx_next;
    logic [31:0] word;
    logic        capture;
    logic        complete;
    logic        start;

    assign lm         = lm_sync_q[SYNC_STAGES-1];
    assign valid_s    = valid_sync_q[SYNC_STAGES-1];
    assign valid_rise = valid_s && !valid_prev;

    // A byte is only taken in LOAD and only once the previous handshake has fully closed.
    assign capture  = (state == LOAD) && valid_rise && !bus.byte_ack;
    assign complete = capture && (byte_idx == 2'd3);
    assign idx_next = capture ? byte_idx + 2'd1 : byte_idx;
    assign start    = ((state == IDLE) || (state == RUN)) && lm;

    assign bus.mem_wdata = word;
    assign bus.cpu_run   = (state == RUN) && !lm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lm_sync_q    <= '0;
            valid_sync_q <= '0;
            valid_prev   <= 1'b0;
        end else begin
            lm_sync_q    <= {lm_sync_q[SYNC_STAGES-2:0], bus.load_mode};
            valid_sync_q <= {valid_sync_q[SYNC_STAGES-2:0], bus.byte_valid};
            valid_prev   <= valid_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            byte_idx       <= 2'd0;
            word           <= 32'd0;
            bus.byte_ack   <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.word_count <= '0;
            bus.load_err   <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;

            if (!valid_s)
                bus.byte_ack <= 1'b0;
            else if (capture)
                bus.byte_ack <= 1'b1;

            // Address and count advance in the cycle after the write pulse; the address saturates.
            if (bus.mem_we) begin
                bus.word_count <= bus.word_count + 1'b1;
                if (bus.mem_addr != LAST_ADDR)
                    bus.mem_addr <= bus.mem_addr + 1'b1;
            end

            if (capture) begin
                word[{byte_idx, 3'b000} +: 8] <= bus.byte_in;
                byte_idx <= idx_next;
                if (complete) begin
                    if (bus.word_count == DEPTH)
                        bus.load_err <= 1'b1;
                    else
                        bus.mem_we <= 1'b1;
                end
            end

            case (state)
                IDLE:    state <= lm ? LOAD : RUN;
                LOAD: begin
                    if (!lm) begin
                        state <= COMMIT;
                        if (idx_next != 2'd0)
                            bus.load_err <= 1'b1;
                    end
                end
                COMMIT:  state <= RUN;
                RUN:     if (lm) state <= LOAD;
                default: state <= IDLE;
            endcase

            if (start) begin
                byte_idx       <= 2'd0;
                bus.mem_addr   <= '0;
                bus.word_count <= '0;
                bus.load_err   <= 1'b0;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Every captured byte is folded in, including overflowed and discarded ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.checksum <= 8'd0;
        else if (start)
            bus.checksum <= 8'd0;
        else if (capture)
            bus.checksum <= bus.checksum ^ bus.byte_in;
    end
`endif
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Host-side program loader for the pipelined RISC-V CPU tile. It is the writer for the program memory that the fetch stage reads.
- It receives instruction bytes from the chip pins using a four-phase strobe/ack handshake and assembles them little-endian into 32-bit words.
- Each completed word is written sequentially into program memory.
- The CPU core is held stopped (cpu_run=0) until loading completes.

Parameters:
- ADDR_W, 5, word-address width; memory depth = 2**ADDR_W words.
- SYNC_STAGES, 2, flip-flop synchronizer depth on byte_valid and load_mode (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load_mode  input  1  pin-level request to enter load mode (asynchronous to clk)
- byte_valid  input  1  host strobe: byte_in is valid (asynchronous to clk)
- byte_in  input  8  instruction byte; host holds it stable while byte_valid=1
- byte_ack  output  1  handshake acknowledge to host
- mem_we  output  1  program-memory write enable, one-cycle pulse
- mem_addr  output  ADDR_W  program-memory word address
- mem_wdata  output  32  assembled instruction word
- cpu_run  output  1  1 = CPU released to execute; 0 = CPU held in reset/stall
- word_count  output  ADDR_W+1  number of words written in the current load session
- load_err  output  1  sticky error: overflow or partial trailing word

Behaviour:
- Reset is asynchronous on rst_n low. All outputs are 0 and the state is IDLE. Synchronizers, byte index, shift register and checksum are all cleared.
- load_mode and byte_valid each pass through SYNC_STAGES flip-flops. An edge detector follows on the synchronized signal.
  - "valid_rise" = synchronized byte_valid is 1 now and was 0 last cycle.
  - "lm" = the synchronized load_mode level.
- IDLE:
  - lm=1 → LOAD. On entry: mem_addr=0, word_count=0, byte_idx=0, load_err=0.
  - lm=0 → RUN.
- LOAD (cpu_run=0):
  - On valid_rise, capture byte_in into lane byte_idx (lane 0 = bits 7:0), increment byte_idx mod 4, and set byte_ack=1.
  - byte_ack clears the first cycle the synchronized byte_valid is 0.
  - A new valid_rise is not accepted while byte_ack=1. The handshake is four-phase.
  - When lane 3 is captured, mem_we=1 on the next cycle, with mem_wdata = the assembled word and mem_addr = the current address.
  - mem_addr and word_count increment in the cycle after the mem_we pulse.
  - If word_count == 2**ADDR_W when a word completes:
    - no write occurs (mem_we stays 0);
    - load_err=1;
    - the word is dropped.
  - mem_addr does not wrap; it saturates at 2**ADDR_W-1.
  - lm falls → COMMIT. If byte_idx != 0, the partial word is discarded and load_err=1.
  - If lm falls in the same cycle that lane 3 is captured, the word is still written (mem_we fires in COMMIT) and no error is raised.
- COMMIT (one cycle): finishes any pending write, then goes to RUN.
- RUN:
  - cpu_run=1.
  - lm rises → LOAD, re-initialized as described on IDLE entry. cpu_run drops in the same cycle the transition is taken.
  - valid_rise in RUN or IDLE is ignored and byte_ack stays 0.
- Resets during LOAD abort the session: the state returns to IDLE and no partial write is issued.
- Latency:
  - byte_valid pin rise → byte_ack=1 in SYNC_STAGES+1 cycles.
  - 4th byte capture → mem_we in 1 cycle.
- mem_we is never asserted outside LOAD or COMMIT.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - An extra output, checksum (8 bits), is added. It holds the running XOR of every byte captured in the current session.
  - checksum is cleared on LOAD entry and held stable in RUN.
  - Overflowed and discarded bytes are still included.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then lm=0 → state RUN within SYNC_STAGES+1 cycles, cpu_run=1, mem_we never pulses.
- lm=1, then send bytes 0x93,0x00,0x50,0x00 with full handshakes → one mem_we pulse, mem_addr=0, mem_wdata=0x00500093, word_count=1, load_err=0.
- Load 3 words, drop lm → addresses 0,1,2 written in order, cpu_run=1 two cycles after synchronized lm falls, word_count=3.
- Send 6 bytes, drop lm → exactly one write, load_err=1, cpu_run=1.
- With ADDR_W=2, send 5 words → four writes to addresses 0..3, fifth dropped, load_err=1, word_count=4. With LOADER_CHECKSUM_EN, checksum equals the XOR of all 20 bytes.
- Assert rst_n low after 2 bytes of a word → all outputs 0. A subsequent load of 0xDEADBEEF bytes (EF,BE,AD,DE) writes 0xDEADBEEF at mem_addr=0.
